lif_stream_driver: RTL and testbench
====================================

Name: lif_stream_driver

Overview:
Host-side initiator for the neuron's byte-serial load/run pin protocol: data byte bus, weights/inputs select, load/run level.
- Accepts one job (weight vector, input vector, run length) over a valid/ready handshake.
- Serialises weights, then inputs, onto the byte bus, then switches the neuron to run mode for the requested number of cycles.
- Counts the returned spikes and reports count plus first-spike index over a second valid/ready handshake.
- Sits between a controller (or test harness) and the neuron's ui_in/uio_in pins.

Parameters:
- N_STAGES, 2, neuron adder-tree depth; must match the attached neuron.
- INPUTS, 2**N_STAGES, synapse count = weight count (derived, not overridden).
- NBYTES, (INPUTS+7)/8, bytes per vector transfer (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  driver accepts job (high only in IDLE)
- job_weights  in  INPUTS  weight bits (1=+1, 0=-1)
- job_inputs  in  INPUTS  input spike bits
- job_cycles  in  8  number of run cycles
- drv_data  out  8  byte bus to neuron ui_in
- drv_sel_w  out  1  to uio_in[0]: 1=weights, 0=inputs
- drv_run  out  1  to uio_in[1]: 1=run/integrate, 0=load
- spike_in  in  1  neuron uo_out[0]
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_count  out  8  spikes counted during run
- res_first  out  8  run-cycle index of first spike (0-based)
- res_fired  out  1  at least one spike occurred

Behaviour:
- Shared clock and reset: one clock (clk); reset is synchronous and active-high.
- Registered outputs: all pin outputs (drv_*) and result outputs are registered.
- Reset values: job_ready=1, res_valid=0, res_count=0, res_first=0, res_fired=0, drv_data=0, drv_sel_w=0, drv_run=0. The neuron is therefore held in load mode with zero inputs, so its membrane is frozen.
- FSM states: IDLE, LOAD_W, LOAD_I, RUN, RESULT.
- IDLE:
  - job_ready=1; drv pins stay at reset values.
  - On job_valid&&job_ready, capture all three job fields, clear counters, go to LOAD_W.
- LOAD_W:
  - NBYTES cycles; drv_sel_w=1, drv_run=0.
  - Byte k (k=0..NBYTES-1) = weights[INPUTS-1-8k -: 8], most significant byte first, to match the receiver's left-shift load.
  - If INPUTS<8: a single byte, the vector zero-extended in the low bits.
- LOAD_I: identical to LOAD_W with the inputs vector and drv_sel_w=0. Then go to RUN, or straight to RESULT if job_cycles==0.
- RUN:
  - Exactly job_cycles cycles; drv_run=1, drv_data=0, drv_sel_w=0.
  - spike_in is sampled at the end of every cycle in which drv_run=1.
  - On each 1: res_count increments.
  - On the first 1: res_first = current run index (0..job_cycles-1) and res_fired=1.
  - res_count cannot overflow (≤255).
- RUN to RESULT transition: drv_run returns to 0 in the cycle following the last run cycle.
- RESULT: res_valid=1 with stable res_*; drv pins at idle values. On res_ready, go to IDLE; res_valid drops next cycle.
- Result field rules:
  - With res_fired=0, res_first reads 0.
  - res_* hold their value until the next job is accepted.
- Latency: job accept in cycle T → first load byte on pins at T+1 → first run cycle at T+2·NBYTES+1 → res_valid at T+2·NBYTES+job_cycles+1.
- job_valid outside IDLE is ignored (job_ready=0); job fields may change freely.
- res_ready is only meaningful when res_valid=1; a res_ready held high continuously gives a one-cycle RESULT.
- Reset mid-operation (any state) → IDLE with reset values; any partial load or count is discarded. drv_run drops to 0 in the cycle after reset is sampled.
- spike_in is ignored outside RUN.

Decomposition:
- Package lif_pkg:
  - state enum (IDLE/LOAD_W/LOAD_I/RUN/RESULT);
  - helper constants INPUTS(N_STAGES) and NBYTES(N_STAGES);
  - pin-bit indices SEL_W_BIT=0, RUN_BIT=1, SPIKE_BIT=0.
- Sub-module lif_byte_serializer:
  - loads an INPUTS-bit vector and emits NBYTES bytes MSB-first, one per cycle, with a last flag;
  - instantiated once and reused for the weights and inputs phases.

Test Plan:
- N_STAGES=2, weights=4'b1111, inputs=4'b1010, cycles=5, spike_in=1 during RUN → pins show (sel_w=1,data=0x0F),(sel_w=0,data=0x0A), then 5 cycles drv_run=1; res_count=5, res_first=0, res_fired=1; res_valid at T+8.
- N_STAGES=4, weights=16'hA55A, inputs=16'h00FF, cycles=3 → bytes 0xA5,0x5A (sel_w=1) then 0x00,0xFF (sel_w=0); spike_in pattern 0,1,1 → count=2, first=1.
- cycles=0 → no cycle with drv_run=1; res_valid at T+2·NBYTES+1; count=0, fired=0, first=0.
- spike_in=0 for 10 cycles → count=0, fired=0; res_ready held low 4 cycles → res_valid and fields stable; then res_ready=1 → IDLE, job_ready=1 next cycle.
- Reset asserted in 3rd RUN cycle (cycles=8) → next cycle drv_run=0, job_ready=1, res_valid=0, res_count=0; a new job then completes normally.
- job_valid held high through a full job → second job accepted only in the cycle job_ready=1 after RESULT handshake; no bytes of the second job overlap the first job's RUN.

Source files
------------

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the LIF neuron stream driver
// Purpose: FSM state encoding, derived vector sizes and neuron pin-bit positions.
// Ports: none (package).
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        RUN,
        RESULT
    } state_t;

    // Bit positions on the neuron's uio_in / uo_out pins
    localparam int SEL_W_BIT = 0;
    localparam int RUN_BIT   = 1;
    localparam int SPIKE_BIT = 0;

    // Synapse count of a neuron with an adder tree of the given depth
    function automatic int lif_inputs(input int n_stages);
        return 1 << n_stages;
    endfunction

    // Bytes needed to carry one weight or input vector
    function automatic int lif_nbytes(input int n_stages);
        return ((1 << n_stages) + 7) / 8;
    endfunction

endpackage

// File: rtl/lif_byte_serializer.sv
// rtl/lif_byte_serializer.sv - MSB-first byte serializer for one weight/input vector
// Purpose: holds a vector and presents it one byte per cycle, most significant byte first.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load, vec       capture a new vector (first byte visible next cycle)
//   advance         step to the next byte
//   clear           drop the vector so data reads zero
//   data            current byte (slice of the holding register)
//   last            current byte is the final one of the vector
module lif_byte_serializer
    import lif_pkg::*;
#(
    parameter int N_STAGES = 2,
    localparam int INPUTS  = lif_inputs(N_STAGES),
    localparam int NBYTES  = lif_nbytes(N_STAGES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [INPUTS-1:0] vec,
    input  logic              advance,
    input  logic              clear,
    output logic [7:0]        data,
    output logic              last
);

    localparam int         PW       = NBYTES * 8;
    localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

    logic [PW-1:0] sreg;
    logic [7:0]    idx;

    // Vectors narrower than a byte are zero-extended so they land in the low bits
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= PW'(vec);
            idx  <= '0;
        end else if (advance) begin
            sreg <= sreg << 8;
            idx  <= idx + 8'd1;
        end
    end

    assign data = sreg[PW-1 -: 8];
    assign last = (idx == LAST_IDX);

endmodule

// File: rtl/lif_stream_driver.sv
// rtl/lif_stream_driver.sv - host-side load/run initiator for the byte-serial LIF neuron
// Purpose: takes a job, loads weights then inputs over the byte bus, runs the neuron
//          for the requested cycles and returns spike count and first-spike index.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   job_valid/job_ready              job handshake
//   job_weights, job_inputs          weight bits (1=+1, 0=-1), input spike bits
//   job_cycles                       run length in cycles
//   drv_data, drv_sel_w, drv_run     neuron ui_in bus, uio_in[0], uio_in[1]
//   spike_in                         neuron uo_out[0]
//   res_valid/res_ready              result handshake
//   res_count, res_first, res_fired  spike count, first spike run index, any spike seen
module lif_stream_driver
    import lif_pkg::*;
#(
    parameter int N_STAGES = 2,
    localparam int INPUTS  = lif_inputs(N_STAGES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [INPUTS-1:0] job_weights,
    input  logic [INPUTS-1:0] job_inputs,
    input  logic [7:0]        job_cycles,
    output logic [7:0]        drv_data,
    output logic              drv_sel_w,
    output logic              drv_run,
    input  logic              spike_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_count,
    output logic [7:0]        res_first,
    output logic              res_fired
);

    state_t            state;
    logic [INPUTS-1:0] inputs_q;
    logic [7:0]        cycles_q;
    logic [7:0]        run_idx;

    logic              ser_load;
    logic              ser_advance;
    logic              ser_clear;
    logic [INPUTS-1:0] ser_vec;
    logic              ser_last;

    // drv_data is taken straight from the serializer register, which is zero
    // whenever no vector is being shifted out (idle, run, result).
    lif_byte_serializer #(.N_STAGES(N_STAGES)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_load),
        .vec     (ser_vec),
        .advance (ser_advance),
        .clear   (ser_clear),
        .data    (drv_data),
        .last    (ser_last)
    );

    // Weights are loaded on job accept, inputs on the last weight byte, and the
    // register is cleared on the last input byte so the bus reads zero in RUN.
    always_comb begin
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        ser_clear   = 1'b0;
        ser_vec     = inputs_q;
        case (state)
            IDLE: begin
                if (job_valid && job_ready) begin
                    ser_load = 1'b1;
                    ser_vec  = job_weights;
                end
            end
            LOAD_W: begin
                if (ser_last) ser_load    = 1'b1;
                else          ser_advance = 1'b1;
            end
            LOAD_I: begin
                if (ser_last) ser_clear   = 1'b1;
                else          ser_advance = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            job_ready <= 1'b1;
            drv_sel_w <= 1'b0;
            drv_run   <= 1'b0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_first <= '0;
            res_fired <= 1'b0;
            inputs_q  <= '0;
            cycles_q  <= '0;
            run_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        inputs_q  <= job_inputs;
                        cycles_q  <= job_cycles;
                        res_count <= '0;
                        res_first <= '0;
                        res_fired <= 1'b0;
                        job_ready <= 1'b0;
                        drv_sel_w <= 1'b1;
                        state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (ser_last) begin
                        drv_sel_w <= 1'b0;
                        state     <= LOAD_I;
                    end
                end
                LOAD_I: begin
                    if (ser_last) begin
                        if (cycles_q == 8'd0) begin
                            res_valid <= 1'b1;
                            state     <= RESULT;
                        end else begin
                            drv_run <= 1'b1;
                            run_idx <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    // run_idx is the index of the cycle whose spike is sampled now
                    if (spike_in) begin
                        res_count <= res_count + 8'd1;
                        if (!res_fired) begin
                            res_fired <= 1'b1;
                            res_first <= run_idx;
                        end
                    end
                    run_idx <= run_idx + 8'd1;
                    if (run_idx == cycles_q - 8'd1) begin
                        drv_run   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    job_ready <= 1'b1;
                    drv_sel_w <= 1'b0;
                    drv_run   <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_stream_driver.sv
// tb/tb_lif_stream_driver.sv - scoreboard bench for lif_stream_driver
module tb_lif_stream_driver;

    localparam int NS = 4;
    localparam int IN = 16;
    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [IN-1:0] job_weights = '0;
    logic [IN-1:0] job_inputs = '0;
    logic [7:0]    job_cycles = '0;
    logic [7:0]    drv_data;
    logic          drv_sel_w;
    logic          drv_run;
    logic          spike_in = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [7:0]    res_count;
    logic [7:0]    res_first;
    logic          res_fired;

    always #5 clk = ~clk;

    lif_stream_driver #(.N_STAGES(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_weights (job_weights),
        .job_inputs  (job_inputs),
        .job_cycles  (job_cycles),
        .drv_data    (drv_data),
        .drv_sel_w   (drv_sel_w),
        .drv_run     (drv_run),
        .spike_in    (spike_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .res_first   (res_first),
        .res_fired   (res_fired)
    );

    typedef struct packed {
        logic       sel_w;
        logic       run;
        logic [7:0] data;
    } pin_t;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] first;
        logic       fired;
    } res_t;

    pin_t         pin_q[$];
    res_t         res_q[$];
    int           n_pass = 0;
    int           n_total = 0;
    logic [255:0] cur_pat = '0;
    int           rr_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: count and first index straight from the spike pattern
    function automatic res_t model_res(input logic [255:0] pat, input int cycles);
        res_t r;
        r = '0;
        for (int i = 0; i < cycles; i++) begin
            if (pat[i]) begin
                if (!r.fired) begin
                    r.fired = 1'b1;
                    r.first = 8'(i);
                end
                r.count = r.count + 8'd1;
            end
        end
        return r;
    endfunction

    // Expected pin activity: weight bytes, input bytes, run cycles, then result
    task automatic push_expect(input logic [IN-1:0] w, input logic [IN-1:0] i,
                               input int cycles, input logic [255:0] pat);
        logic [IN-1:0] s;
        for (int k = 0; k < NB; k++) begin
            s = w >> (IN - 8 - 8 * k);
            pin_q.push_back('{1'b1, 1'b0, s[7:0]});
        end
        for (int k = 0; k < NB; k++) begin
            s = i >> (IN - 8 - 8 * k);
            pin_q.push_back('{1'b0, 1'b0, s[7:0]});
        end
        for (int k = 0; k < cycles; k++) pin_q.push_back('{1'b0, 1'b1, 8'h00});
        res_q.push_back(model_res(pat, cycles));
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic submit(input logic [IN-1:0] w, input logic [IN-1:0] i, input logic [7:0] c,
                          input logic [255:0] pat, input bit keep);
        bit ok;
        ok = 1'b0;
        job_weights = w;
        job_inputs  = i;
        job_cycles  = c;
        job_valid   = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("job_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) begin
            push_expect(w, i, int'(c), pat);
            cur_pat = pat;
        end
        #1;
        if (keep && ok) begin
            job_weights = IN'($urandom);
            job_inputs  = IN'($urandom);
            job_cycles  = 8'($urandom);
        end else begin
            job_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit empty;
        empty = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (pin_q.size() == 0 && res_q.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        chk("drain", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares pins and results against the scoreboard every cycle
    always @(negedge clk) begin
        pin_t e;
        res_t r;
        if (!reset) begin
            if (pin_q.size() > 0) begin
                e = pin_q.pop_front();
                chk("pins", 32'({drv_sel_w, drv_run, drv_data}), 32'(e));
                chk("busy_ready", 32'({job_ready, res_valid}), 32'd0);
            end else if (res_q.size() > 0) begin
                r = res_q[0];
                chk("res_pins", 32'({drv_sel_w, drv_run, drv_data, job_ready}), 32'd0);
                chk("res_valid", 32'(res_valid), 32'd1);
                if (res_valid) begin
                    chk("res_fields", 32'({res_count, res_first, res_fired}), 32'(r));
                    if (res_ready) void'(res_q.pop_front());
                end
            end else begin
                chk("idle", 32'({drv_sel_w, drv_run, drv_data, job_ready, res_valid}), 32'b10);
            end
        end
    end

    // Spike source: follows the job's pattern during run, noise elsewhere
    initial begin : spike_drv
        int   k;
        logic prev;
        k    = 0;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (drv_run) begin
                spike_in = cur_pat[k];
                k++;
            end else begin
                if (prev) k = 0;
                spike_in = 1'($urandom);
            end
            prev = drv_run;
        end
    end

    initial begin : rr_drv
        forever begin
            @(posedge clk);
            #1;
            res_ready = (rr_mode == 2) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom);
        end
    end

    initial begin : main
        logic [255:0] ones;
        int           n;
        ones = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_job_ready", 32'(job_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'({res_count, res_first, res_fired}), 32'd0);
        chk("rst_drv", 32'({drv_data, drv_sel_w, drv_run}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        submit(16'hA55A, 16'h00FF, 8'd3, 256'h6, 1'b0);
        submit(16'($urandom), 16'($urandom), 8'd0, '0, 1'b0);
        submit(16'h1234, 16'hFEDC, 8'd5, ones, 1'b0);

        wait_drain();
        rr_mode = 1;
        submit(16'hFFFF, 16'h0F0F, 8'd10, '0, 1'b0);
        n = 0;
        while (n < 100 && !res_valid) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rv_seen", 32'(res_valid), 32'd1);
        repeat (4) @(negedge clk);
        rr_mode = 2;
        wait_drain();
        rr_mode = 0;

        submit(16'h8001, 16'h7FFE, 8'd8, ones, 1'b0);
        n = 0;
        while (n < 3) begin
            @(posedge clk);
            #1;
            if (drv_run) n++;
        end
        reset = 1'b1;
        @(posedge clk);
        pin_q.delete();
        res_q.delete();
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_run", 32'(drv_run), 32'd0);
        chk("rst_mid_ready", 32'(job_ready), 32'd1);
        chk("rst_mid_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_count", 32'(res_count), 32'd0);
        @(posedge clk);
        #1;
        submit(16'h0F0F, 16'hF00F, 8'd4, 256'h9, 1'b0);

        submit(16'hC3C3, 16'h3C3C, 8'd4, 256'hA, 1'b1);
        submit(16'h5AA5, 16'h9669, 8'd6, 256'h20, 1'b0);

        for (int j = 0; j < 20; j++) begin
            submit(16'($urandom), 16'($urandom), 8'($urandom_range(0, 20)),
                   {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        wait_drain();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
